// File: rtl/fb_sram_arbiter.sv
// Frame-copy write FIFO arbitrated against VGA pixel reads onto one registered SRAM port.
// Optional build macro FB_ARB_STATS_EN adds the wr_stall_cnt write-stall counter output.
module fb_sram_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              copy_start,
  input  logic              copy_valid,
  input  logic              copy_last,
  input  logic [ADDR_W-1:0] copy_addr,
  input  logic [DATA_W-1:0] copy_data,
  output logic              copy_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              sram_rd,
  output logic              sram_wr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              frame_done,
`ifdef FB_ARB_STATS_EN
  output logic [15:0]       wr_stall_cnt,
`endif
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;

  state_t              state_reg;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [PW:0]         wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic                full, empty, full_next, push, pop;
  logic [EW-1:0]       head;
  logic                copy_ready_reg, busy_reg, frame_done_reg;
  logic                sram_rd_reg, sram_wr_reg, sram_last_reg;
  logic [ADDR_W-1:0]   sram_addr_reg;
  logic [DATA_W-1:0]   sram_wdata_reg;
  logic                rd_valid_reg;
  logic [DATA_W-1:0]   rd_data_reg;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) && (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign push  = copy_valid && copy_ready_reg && (state_reg == COPY);
  assign pop   = !rd_req && !empty;

  assign wr_ptr_next = wr_ptr_reg + (PW+1)'(push);
  assign rd_ptr_next = rd_ptr_reg + (PW+1)'(pop);
  assign full_next   = (wr_ptr_next[PW] != rd_ptr_next[PW]) &&
                       (wr_ptr_next[PW-1:0] == rd_ptr_next[PW-1:0]);

  assign head = mem[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[PW-1:0]] <= {copy_last, copy_addr, copy_data};
  end

  // copy_ready tracks !full of the pointers it will see next cycle, so it is 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      copy_ready_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      copy_ready_reg <= !full_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_rd_reg    <= 1'b0;
      sram_wr_reg    <= 1'b0;
      sram_last_reg  <= 1'b0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
    end else begin
      sram_rd_reg   <= rd_req;
      sram_wr_reg   <= pop;
      sram_last_reg <= pop && head[EW-1];
      if (rd_req) begin
        sram_addr_reg <= rd_addr;
      end else if (pop) begin
        sram_addr_reg  <= head[DATA_W +: ADDR_W];
        sram_wdata_reg <= head[DATA_W-1:0];
      end
      rd_valid_reg <= sram_rd_reg;
      if (sram_rd_reg) rd_data_reg <= sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (copy_start) begin
          state_reg <= COPY;
          busy_reg  <= 1'b1;
        end
        COPY: if (push && copy_last) state_reg <= DRAIN;
        // The final entry is done once its write is actually on the SRAM port.
        DRAIN: if (sram_wr_reg && sram_last_reg) begin
          state_reg      <= DONE;
          frame_done_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (copy_start) begin
      stall_cnt_reg <= '0;
    end else if (!empty && rd_req && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign wr_stall_cnt = stall_cnt_reg;
`endif

  assign copy_ready = copy_ready_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign sram_rd    = sram_rd_reg;
  assign sram_wr    = sram_wr_reg;
  assign sram_addr  = sram_addr_reg;
  assign sram_wdata = sram_wdata_reg;
  assign rd_valid   = rd_valid_reg;
  assign rd_data    = rd_data_reg;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed vector table plus hand-written sequences for fb_sram_arbiter.
module tb_fb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        copy_start, copy_valid, copy_last;
  logic [19:0] copy_addr;
  logic [7:0]  copy_data;
  logic        copy_ready;
  logic        rd_req;
  logic [19:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        sram_rd, sram_wr;
  logic [19:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata;
  logic        frame_done, busy;
`ifdef FB_ARB_STATS_EN
  logic [15:0] wr_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fb_sram_arbiter #(.DATA_W(8), .ADDR_W(20), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .copy_start(copy_start), .copy_valid(copy_valid), .copy_last(copy_last),
    .copy_addr(copy_addr), .copy_data(copy_data), .copy_ready(copy_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .sram_rd(sram_rd), .sram_wr(sram_wr), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .frame_done(frame_done),
`ifdef FB_ARB_STATS_EN
    .wr_stall_cnt(wr_stall_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    logic cs, cv, cl;
    logic [19:0] caddr;
    logic [7:0]  cdata;
    logic rq;
    logic [19:0] raddr;
    logic [7:0]  rdata;
    logic e_rd, e_wr;
    logic [19:0] e_addr;
    logic [7:0]  e_wd;
    logic e_rv;
    logic [7:0]  e_rdat;
    logic e_fd, e_busy, e_crdy;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  function automatic vec_t mk(logic cs, logic cv, logic cl, logic [19:0] caddr, logic [7:0] cdata,
                              logic rq, logic [19:0] raddr, logic [7:0] rdata,
                              logic e_rd, logic e_wr, logic [19:0] e_addr, logic [7:0] e_wd,
                              logic e_rv, logic [7:0] e_rdat, logic e_fd, logic e_busy, logic e_crdy);
    vec_t v;
    v.cs = cs; v.cv = cv; v.cl = cl; v.caddr = caddr; v.cdata = cdata;
    v.rq = rq; v.raddr = raddr; v.rdata = rdata;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_rv = e_rv; v.e_rdat = e_rdat; v.e_fd = e_fd; v.e_busy = e_busy; v.e_crdy = e_crdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    copy_start = 0; copy_valid = 0; copy_last = 0; copy_addr = '0; copy_data = '0;
    rd_req = 0; rd_addr = '0; sram_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " sram_rd"}, sram_rd, 0);
    chk({tag, " sram_wr"}, sram_wr, 0);
    chk({tag, " sram_addr"}, sram_addr, 0);
    chk({tag, " sram_wdata"}, sram_wdata, 0);
    chk({tag, " rd_valid"}, rd_valid, 0);
    chk({tag, " rd_data"}, rd_data, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " copy_ready"}, copy_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cs cv cl caddr    cd     rq raddr     rdata  rd wr addr      wd     rv rdat   fd bz cr
    tbl[0]  = mk(0, 0, 0, 20'h0,  8'h00, 1, 20'h00123, 8'h5A, 1, 0, 20'h00123, 8'h00, 0, 8'h00, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'h5A, 0, 0, 20'h00123, 8'h00, 1, 8'h5A, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'h00, 0, 0, 20'h00123, 8'h00, 0, 8'h5A, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'h00, 0, 0, 20'h00123, 8'h00, 0, 8'h5A, 0, 1, 1);
    tbl[4]  = mk(0, 1, 0, 20'h10, 8'h01, 0, 20'h0,     8'h00, 0, 0, 20'h00123, 8'h00, 0, 8'h5A, 0, 1, 1);
    tbl[5]  = mk(0, 1, 0, 20'h11, 8'h02, 0, 20'h0,     8'h00, 0, 1, 20'h00010, 8'h01, 0, 8'h5A, 0, 1, 1);
    tbl[6]  = mk(0, 1, 0, 20'h12, 8'h03, 0, 20'h0,     8'h00, 0, 1, 20'h00011, 8'h02, 0, 8'h5A, 0, 1, 1);
    tbl[7]  = mk(0, 1, 1, 20'h13, 8'h04, 0, 20'h0,     8'h00, 0, 1, 20'h00012, 8'h03, 0, 8'h5A, 0, 1, 1);
    tbl[8]  = mk(0, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'h00, 0, 1, 20'h00013, 8'h04, 0, 8'h5A, 0, 1, 1);
    tbl[9]  = mk(0, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'h00, 0, 0, 20'h00013, 8'h04, 0, 8'h5A, 1, 1, 1);
    tbl[10] = mk(0, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'h00, 0, 0, 20'h00013, 8'h04, 0, 8'h5A, 0, 0, 1);
    // copy_valid in IDLE must be dropped: no write ever follows
    tbl[11] = mk(0, 1, 0, 20'h55, 8'h77, 0, 20'h0,     8'h00, 0, 0, 20'h00013, 8'h04, 0, 8'h5A, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'h00, 0, 0, 20'h00013, 8'h04, 0, 8'h5A, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 20'h0,  8'h00, 1, 20'h00200, 8'h00, 1, 0, 20'h00200, 8'h04, 0, 8'h5A, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 20'h0,  8'h00, 1, 20'h00201, 8'hC3, 1, 0, 20'h00201, 8'h04, 1, 8'hC3, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'h3C, 0, 0, 20'h00201, 8'h04, 1, 8'h3C, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 20'h0,  8'h00, 0, 20'h0,     8'hFF, 0, 0, 20'h00201, 8'h04, 0, 8'h3C, 0, 0, 1);

    // Reset held with random inputs
    reset = 0;
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      copy_start = 1'($urandom_range(0, 1));
      copy_valid = 1'($urandom_range(0, 1));
      copy_last  = 1'($urandom_range(0, 1));
      copy_addr  = 20'($urandom);
      copy_data  = 8'($urandom);
      rd_req     = 1'($urandom_range(0, 1));
      rd_addr    = 20'($urandom);
      sram_rdata = 8'($urandom);
      tick();
      chk_all_zero($sformatf("reset%0d", k));
    end
    idle_inputs();
    #4 reset = 1;
    tick();
    chk("post-reset copy_ready", copy_ready, 1);
    chk("post-reset busy", busy, 0);
    chk("post-reset sram_wr", sram_wr, 0);

    // Table: single read, 4-word copy, dropped IDLE push, pipelined reads
    for (int i = 0; i < NV; i++) begin
      copy_start = tbl[i].cs; copy_valid = tbl[i].cv; copy_last = tbl[i].cl;
      copy_addr = tbl[i].caddr; copy_data = tbl[i].cdata;
      rd_req = tbl[i].rq; rd_addr = tbl[i].raddr; sram_rdata = tbl[i].rdata;
      tick();
      chk($sformatf("v%0d sram_rd", i), sram_rd, tbl[i].e_rd);
      chk($sformatf("v%0d sram_wr", i), sram_wr, tbl[i].e_wr);
      chk($sformatf("v%0d sram_addr", i), sram_addr, tbl[i].e_addr);
      chk($sformatf("v%0d sram_wdata", i), sram_wdata, tbl[i].e_wd);
      chk($sformatf("v%0d rd_valid", i), rd_valid, tbl[i].e_rv);
      chk($sformatf("v%0d rd_data", i), rd_data, tbl[i].e_rdat);
      chk($sformatf("v%0d frame_done", i), frame_done, tbl[i].e_fd);
      chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d copy_ready", i), copy_ready, tbl[i].e_crdy);
    end
    idle_inputs();

    // Contention: reads hold off queued writes
    copy_start = 1;
    tick();
    copy_start = 0;
    for (int i = 0; i < 3; i++) begin
      copy_valid = 1; copy_addr = 20'h20 + 20'(i); copy_data = 8'hA0 + 8'(i);
      rd_req = 1; rd_addr = 20'h300 + 20'(i);
      tick();
      chk($sformatf("cont push%0d sram_rd", i), sram_rd, 1);
      chk($sformatf("cont push%0d sram_wr", i), sram_wr, 0);
      chk($sformatf("cont push%0d sram_addr", i), sram_addr, 20'h300 + 20'(i));
    end
    copy_valid = 0;
    for (int k = 0; k < 5; k++) begin
      rd_addr = 20'h400 + 20'(k);
      tick();
      chk($sformatf("cont rd%0d sram_rd", k), sram_rd, 1);
      chk($sformatf("cont rd%0d sram_wr", k), sram_wr, 0);
      chk($sformatf("cont rd%0d sram_addr", k), sram_addr, 20'h400 + 20'(k));
    end
`ifdef FB_ARB_STATS_EN
    // 2 stalled cycles during the pushes plus 5 with three entries queued
    chk("cont wr_stall_cnt", wr_stall_cnt, 7);
`endif
    rd_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("cont wr%0d sram_wr", i), sram_wr, 1);
      chk($sformatf("cont wr%0d sram_rd", i), sram_rd, 0);
      chk($sformatf("cont wr%0d sram_addr", i), sram_addr, 20'h20 + 20'(i));
      chk($sformatf("cont wr%0d sram_wdata", i), sram_wdata, 8'hA0 + 8'(i));
    end
    tick();
    chk("cont drained sram_wr", sram_wr, 0);
    copy_valid = 1; copy_last = 1; copy_addr = 20'h2F; copy_data = 8'hEE;
    tick();
    copy_valid = 0; copy_last = 0;
    chk("cont last push sram_wr", sram_wr, 0);
    tick();
    chk("cont last sram_wr", sram_wr, 1);
    chk("cont last sram_addr", sram_addr, 20'h2F);
    chk("cont last frame_done", frame_done, 0);
    tick();
    chk("cont frame_done", frame_done, 1);
    chk("cont busy in DONE", busy, 1);
    copy_start = 1;
    tick();
    copy_start = 0;
    chk("cont after DONE frame_done", frame_done, 0);
    chk("cont start-in-DONE ignored busy", busy, 0);
    tick();
    chk("cont idle busy", busy, 0);

    // Full FIFO under continuous reads
    copy_start = 1;
    tick();
    copy_start = 0;
`ifdef FB_ARB_STATS_EN
    chk("full wr_stall_cnt cleared", wr_stall_cnt, 0);
`endif
    rd_req = 1; rd_addr = 20'h500;
    for (int i = 0; i < 8; i++) begin
      copy_valid = 1; copy_addr = 20'h40 + 20'(i); copy_data = 8'h80 + 8'(i);
      chk($sformatf("full pre%0d copy_ready", i), copy_ready, 1);
      tick();
      chk($sformatf("full push%0d sram_wr", i), sram_wr, 0);
    end
    chk("full copy_ready after 8", copy_ready, 0);
    copy_last = 1; copy_addr = 20'h48; copy_data = 8'h99;
    tick();
    chk("full 9th copy_ready", copy_ready, 0);
    chk("full 9th busy", busy, 1);
    rd_req = 0;
    tick();
    copy_valid = 0; copy_last = 0;
    chk("full drain0 sram_wr", sram_wr, 1);
    chk("full drain0 sram_addr", sram_addr, 20'h40);
    chk("full drain0 copy_ready", copy_ready, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("full drain%0d sram_wr", i), sram_wr, 1);
      chk($sformatf("full drain%0d sram_addr", i), sram_addr, 20'h40 + 20'(i));
      chk($sformatf("full drain%0d sram_wdata", i), sram_wdata, 8'h80 + 8'(i));
    end
    tick();
    chk("full 9th never written", sram_wr, 0);
    chk("full still COPY busy", busy, 1);

    // Reset in DRAIN with two entries pending
    rd_req = 1; rd_addr = 20'h600;
    copy_valid = 1; copy_addr = 20'h60; copy_data = 8'h61;
    tick();
    copy_last = 1; copy_addr = 20'h61; copy_data = 8'h62;
    tick();
    copy_valid = 0; copy_last = 0;
    chk("mid busy before reset", busy, 1);
    chk("mid sram_wr before reset", sram_wr, 0);
    #3 reset = 0;
    rd_req = 0;
    #1;
    chk_all_zero("mid async");
    tick();
    tick();
    #4 reset = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mid post%0d sram_wr", k), sram_wr, 0);
      chk($sformatf("mid post%0d frame_done", k), frame_done, 0);
      chk($sformatf("mid post%0d busy", k), busy, 0);
    end
    chk("mid post copy_ready", copy_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
